// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, ALU operation classes and the instruction field constants.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        IEXEC  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        JAL    = 4'd11
    } state_t;

    // ALU_control opcode classes
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;

    // instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // instruction[5:0]
    localparam logic [5:0] FN_JR    = 6'b001000;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, OP_JAL};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// strobes and mux selects out. master = controller, slave = datapath.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic       timeout;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src,
               alu_op, illegal, timeout, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src,
               alu_op, illegal, timeout, state
    );
endinterface

// File: rtl/mc_output_decode.sv
// State -> datapath strobe/select decode. Moore apart from the FETCH
// write-enables (wait for mem_ready), jr in EXEC, the illegal-opcode
// pulse in DECODE and the timeout pulse (mem_abort).
module mc_output_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       mem_abort,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic       timeout
);

    // Decode the current state; everything stays quiet while reset is high
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_b     = 2'd0;
        pc_src        = 2'd0;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;
        timeout       = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_read  = !mem_abort;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    alu_src_b = 2'd1;
                    timeout   = mem_abort;
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    illegal   = !is_legal_op(opcode);
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = !mem_abort;
                    timeout  = mem_abort;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = !mem_abort;
                    timeout   = mem_abort;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RTYPE;
                    if (funct == FN_JR) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                    end
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd1;
                end
                IEXEC: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'd1;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
                JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: instruction sequencing FSM plus the
// memory wait counter that bounds every FETCH/MEMRD/MEMWR access.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
)
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_state;
    logic          at_limit;
    logic          mem_abort;

    // A ready arriving on the limit cycle still completes the access
    assign mem_state = state inside {FETCH, MEMRD, MEMWR};
    assign at_limit  = (wait_cnt == WAIT_LIMIT);
    assign mem_abort = mem_state && at_limit && !bus.mem_ready;

    // Sequence instructions; the counter clears on any transition (including
    // a FETCH -> FETCH retry) and only counts while a memory access stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (bus.mem_ready)  state    <= DECODE;
                    else if (!at_limit) wait_cnt <= wait_cnt + 1'b1;
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXEC;
                        OP_ADDI:      state <= IEXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        OP_JAL:       state <= JAL;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: state <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (bus.mem_ready) state    <= MEMWB;
                    else if (at_limit) state    <= FETCH;
                    else               wait_cnt <= wait_cnt + 1'b1;
                end
                MEMWR: begin
                    if (bus.mem_ready || at_limit) state    <= FETCH;
                    else                           wait_cnt <= wait_cnt + 1'b1;
                end
                EXEC:    state <= (bus.funct == FN_JR) ? FETCH : ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.state = state;

    mc_output_decode u_decode (
        .rst           (rst),
        .state         (state),
        .opcode        (bus.opcode),
        .funct         (bus.funct),
        .mem_ready     (bus.mem_ready),
        .mem_abort     (mem_abort),
        .pc_write      (bus.pc_write),
        .pc_write_cond (bus.pc_write_cond),
        .iord          (bus.iord),
        .mem_read      (bus.mem_read),
        .mem_write     (bus.mem_write),
        .ir_write      (bus.ir_write),
        .reg_write     (bus.reg_write),
        .alu_src_a     (bus.alu_src_a),
        .reg_dst       (bus.reg_dst),
        .mem_to_reg    (bus.mem_to_reg),
        .alu_src_b     (bus.alu_src_b),
        .pc_src        (bus.pc_src),
        .alu_op        (bus.alu_op),
        .illegal       (bus.illegal),
        .timeout       (bus.timeout)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table for the instruction
// classes plus hand-written sequences for branches, timeouts and reset.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    // strb bit order: pc_write pc_write_cond iord mem_read mem_write
    //                 ir_write reg_write alu_src_a illegal timeout
    typedef struct packed {
        logic [3:0] st;
        logic [9:0] strb;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic [1:0] asb;
        logic [1:0] psrc;
        logic [2:0] aop;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        obs_t       exp;
    } vec_t;

    localparam logic [5:0]  FN_ADD  = 6'b100000;
    localparam logic [5:0]  OP_BAD  = 6'b111111;
    localparam logic [31:0] BR_TGT  = 32'h0000_0100;
    localparam logic [31:0] J_TGT   = 32'h0000_0200;
    localparam logic [31:0] JR_TGT  = 32'h0000_0300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    obs_t        sb[$];
    vec_t        vt[$];
    logic [31:0] pc;
    logic [31:0] pc_snap;

    obs_t e_reset, e_fetch, e_fwait, e_ftmo, e_dec, e_dec_ill, e_madr, e_mrd;
    obs_t e_mwb, e_mwr, e_exec, e_exec_jr, e_aluwb, e_iexec, e_branch, e_jump, e_jal;

    function automatic obs_t mk(input logic [3:0] st, input logic [9:0] strb,
                                input logic [1:0] rdst, input logic [1:0] m2r,
                                input logic [1:0] asb, input logic [1:0] psrc,
                                input logic [2:0] aop);
        obs_t o;
        o.st = st; o.strb = strb; o.rdst = rdst; o.m2r = m2r;
        o.asb = asb; o.psrc = psrc; o.aop = aop;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st   = bus.state;
        o.strb = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_write, bus.alu_src_a,
                  bus.illegal, bus.timeout};
        o.rdst = bus.reg_dst;
        o.m2r  = bus.mem_to_reg;
        o.asb  = bus.alu_src_b;
        o.psrc = bus.pc_src;
        o.aop  = bus.alu_op;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d strb=%b rdst=%0d m2r=%0d asb=%0d psrc=%0d aop=%0d",
                         o.st, o.strb, o.rdst, o.m2r, o.asb, o.psrc, o.aop);
    endfunction

    task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {%s} expected {%s}", nm, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_pc(input string nm, input logic [31:0] exp);
        checks++;
        if (pc !== exp) begin
            failures++;
            $display("FAIL %s: pc got %h expected %h", nm, pc, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, sample mid-low-phase,
    // then update the datapath PC model from the strobes seen at the edge.
    task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input obs_t exp);
        obs_t got;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        sb.push_back(exp);
        #2;
        got = sample();
        check_obs(nm, got, sb.pop_front());
        if (got.strb[9] || (got.strb[8] && z)) begin
            case (got.psrc)
                2'd0: pc = pc + 32'd4;
                2'd1: pc = BR_TGT;
                2'd2: pc = J_TGT;
                default: pc = JR_TGT;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input obs_t e);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.exp = e;
        vt.push_back(v);
    endtask

    initial begin
        e_reset   = '0;
        e_fetch   = mk(FETCH,  10'b1001010000, 2'd0, 2'd0, 2'd1, 2'd0, ALU_ADD);
        e_fwait   = mk(FETCH,  10'b0001000000, 2'd0, 2'd0, 2'd1, 2'd0, ALU_ADD);
        e_ftmo    = mk(FETCH,  10'b0000000001, 2'd0, 2'd0, 2'd1, 2'd0, ALU_ADD);
        e_dec     = mk(DECODE, 10'b0000000000, 2'd0, 2'd0, 2'd3, 2'd0, ALU_ADD);
        e_dec_ill = mk(DECODE, 10'b0000000010, 2'd0, 2'd0, 2'd3, 2'd0, ALU_ADD);
        e_madr    = mk(MEMADR, 10'b0000000100, 2'd0, 2'd0, 2'd2, 2'd0, ALU_ADD);
        e_mrd     = mk(MEMRD,  10'b0011000000, 2'd0, 2'd0, 2'd0, 2'd0, ALU_ADD);
        e_mwb     = mk(MEMWB,  10'b0000001000, 2'd0, 2'd1, 2'd0, 2'd0, ALU_ADD);
        e_mwr     = mk(MEMWR,  10'b0010100000, 2'd0, 2'd0, 2'd0, 2'd0, ALU_ADD);
        e_exec    = mk(EXEC,   10'b0000000100, 2'd0, 2'd0, 2'd0, 2'd0, ALU_RTYPE);
        e_exec_jr = mk(EXEC,   10'b1000000100, 2'd0, 2'd0, 2'd0, 2'd3, ALU_RTYPE);
        e_aluwb   = mk(ALUWB,  10'b0000001000, 2'd1, 2'd0, 2'd0, 2'd0, ALU_ADD);
        e_iexec   = mk(IEXEC,  10'b0000001100, 2'd0, 2'd0, 2'd2, 2'd0, ALU_ADD);
        e_branch  = mk(BRANCH, 10'b0100000100, 2'd0, 2'd0, 2'd0, 2'd1, ALU_SUB);
        e_jump    = mk(JUMP,   10'b1000000000, 2'd0, 2'd0, 2'd0, 2'd2, ALU_ADD);
        e_jal     = mk(JAL,    10'b1000001000, 2'd2, 2'd2, 2'd0, 2'd2, ALU_ADD);

        // lw, memory always ready: reg_write only in the fifth cycle
        add(OP_LW, 6'd0, 1'b1, e_fetch);
        add(OP_LW, 6'd0, 1'b0, e_dec);
        add(OP_LW, 6'd0, 1'b0, e_madr);
        add(OP_LW, 6'd0, 1'b1, e_mrd);
        add(OP_LW, 6'd0, 1'b0, e_mwb);
        // sw, ready three cycles late: mem_write for four cycles
        add(OP_SW, 6'd0, 1'b1, e_fetch);
        add(OP_SW, 6'd0, 1'b0, e_dec);
        add(OP_SW, 6'd0, 1'b0, e_madr);
        add(OP_SW, 6'd0, 1'b0, e_mwr);
        add(OP_SW, 6'd0, 1'b0, e_mwr);
        add(OP_SW, 6'd0, 1'b0, e_mwr);
        add(OP_SW, 6'd0, 1'b1, e_mwr);
        // R-type add
        add(OP_RTYPE, FN_ADD, 1'b1, e_fetch);
        add(OP_RTYPE, FN_ADD, 1'b0, e_dec);
        add(OP_RTYPE, FN_ADD, 1'b0, e_exec);
        add(OP_RTYPE, FN_ADD, 1'b0, e_aluwb);
        // addi
        add(OP_ADDI, 6'd0, 1'b1, e_fetch);
        add(OP_ADDI, 6'd0, 1'b0, e_dec);
        add(OP_ADDI, 6'd0, 1'b0, e_iexec);
        // jr
        add(OP_RTYPE, FN_JR, 1'b1, e_fetch);
        add(OP_RTYPE, FN_JR, 1'b0, e_dec);
        add(OP_RTYPE, FN_JR, 1'b0, e_exec_jr);
        // j
        add(OP_J, 6'd0, 1'b1, e_fetch);
        add(OP_J, 6'd0, 1'b0, e_dec);
        add(OP_J, 6'd0, 1'b0, e_jump);
        // jal
        add(OP_JAL, 6'd0, 1'b1, e_fetch);
        add(OP_JAL, 6'd0, 1'b0, e_dec);
        add(OP_JAL, 6'd0, 1'b0, e_jal);
        // illegal opcode: pulse in DECODE, straight back to FETCH
        add(OP_BAD, 6'd0, 1'b1, e_fetch);
        add(OP_BAD, 6'd0, 1'b0, e_dec_ill);

        pc            = 32'd0;
        rst           = 1'b1;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_obs("reset_state", sample(), e_reset);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i])
            step($sformatf("tbl[%0d]", i), vt[i].op, vt[i].fn, 1'b0, vt[i].rdy, vt[i].exp);

        // beq not taken: PC must keep the fetch-incremented value
        step("beq0_fetch", OP_BEQ, 6'd0, 1'b0, 1'b1, e_fetch);
        step("beq0_dec",   OP_BEQ, 6'd0, 1'b0, 1'b0, e_dec);
        pc_snap = pc;
        step("beq0_branch", OP_BEQ, 6'd0, 1'b0, 1'b0, e_branch);
        check_pc("beq0_pc", pc_snap);

        // beq taken: PC loads the branch target
        step("beq1_fetch",  OP_BEQ, 6'd0, 1'b1, 1'b1, e_fetch);
        step("beq1_dec",    OP_BEQ, 6'd0, 1'b1, 1'b0, e_dec);
        step("beq1_branch", OP_BEQ, 6'd0, 1'b1, 1'b0, e_branch);
        check_pc("beq1_pc", BR_TGT);

        // fetch stalls 15 cycles: timeout pulse with mem_read dropped, refetch
        repeat (15) step("fetch_wait", OP_LW, 6'd0, 1'b0, 1'b0, e_fwait);
        step("fetch_timeout", OP_LW, 6'd0, 1'b0, 1'b0, e_ftmo);
        step("refetch",       OP_LW, 6'd0, 1'b0, 1'b1, e_fetch);

        // ready on the limit cycle of MEMRD is a successful read
        step("lim_dec",  OP_LW, 6'd0, 1'b0, 1'b0, e_dec);
        step("lim_madr", OP_LW, 6'd0, 1'b0, 1'b0, e_madr);
        repeat (15) step("lim_wait", OP_LW, 6'd0, 1'b0, 1'b0, e_mrd);
        step("lim_ready", OP_LW, 6'd0, 1'b0, 1'b1, e_mrd);
        step("lim_memwb", OP_LW, 6'd0, 1'b0, 1'b0, e_mwb);

        // reset during a MEMRD stall: immediate quiet outputs, fresh FETCH after
        step("rst_fetch", OP_LW, 6'd0, 1'b0, 1'b1, e_fetch);
        step("rst_dec",   OP_LW, 6'd0, 1'b0, 1'b0, e_dec);
        step("rst_madr",  OP_LW, 6'd0, 1'b0, 1'b0, e_madr);
        step("rst_wait",  OP_LW, 6'd0, 1'b0, 1'b0, e_mrd);
        bus.mem_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_obs("rst_async", sample(), e_reset);
        @(negedge clk);
        check_obs("rst_held", sample(), e_reset);
        rst = 1'b0;
        step("post_rst_wait",  OP_LW, 6'd0, 1'b0, 1'b0, e_fwait);
        step("post_rst_fetch", OP_LW, 6'd0, 1'b0, 1'b1, e_fetch);
        step("post_rst_dec",   OP_LW, 6'd0, 1'b0, 1'b0, e_dec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15: maximum memory wait cycles per access before timeout.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port opcode  input  6  instruction[31:26] held in the instruction register.
REQ-005 The block SHALL have port funct  input  6  instruction[5:0] held in the instruction register.
REQ-006 The block SHALL have port zero  input  1  ALU zero flag.
REQ-007 The block SHALL have port mem_ready  input  1  shared memory has completed the current access.
REQ-008 The block SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a  output  1 each  datapath strobes and selects.
REQ-009 The block SHALL have outputs reg_dst, mem_to_reg, alu_src_b, pc_src  output  2 each  datapath mux selects (reg_dst/mem_to_reg 2 = $ra/PC+4).
REQ-010 The block SHALL have output alu_op  output  3  ALU_control opcode class.
REQ-011 The block SHALL have outputs illegal, timeout  output  1 each  one-cycle error pulses; state  output  4  current FSM state, for debug.

Function
REQ-012 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, BRANCH, JUMP, JAL.
- All outputs are Moore (a function of state only), except pc_write_cond, ir_write, pc_write and the pulses, which are also qualified by mem_ready/zero as stated below.
REQ-013 FETCH SHALL assert mem_read with iord=0 and hold until mem_ready=1; in that same cycle it SHALL assert ir_write and pc_write (alu_src_a=0, alu_src_b=1, pc_src=0), then go to DECODE.
REQ-014 DECODE SHALL compute the branch target (alu_src_a=0, alu_src_b=3, alu_op=ADD) and dispatch on opcode:
- 100011/101011 -> MEMADR
- 000000 -> EXEC
- 001000 -> IEXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- 000011 -> JAL
- any other opcode -> FETCH with illegal=1 for one cycle.
REQ-015 MEMADR SHALL use alu_src_a=1, alu_src_b=2, alu_op=ADD, then go to MEMRD (lw) or MEMWR (sw).
REQ-016 MEMRD/MEMWR SHALL drive iord=1 with mem_read or mem_write held steady until mem_ready=1, then go to MEMWB (lw) or FETCH (sw).
REQ-017 MEMWB SHALL assert reg_write with reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-018 EXEC SHALL use alu_src_a=1, alu_src_b=0, alu_op=RTYPE, then go to ALUWB.
- If funct=001000 (jr), EXEC SHALL instead assert pc_write with pc_src=3 and go to FETCH, with no register write.
REQ-019 ALUWB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0; IEXEC SHALL assert reg_write with reg_dst=0, alu_src_b=2, alu_op=ADD. Both SHALL then go to FETCH.
REQ-020 BRANCH SHALL use alu_op=SUB, assert pc_write_cond with pc_src=1 (PC updates only if zero=1), then go to FETCH.
REQ-021 JUMP SHALL assert pc_write with pc_src=2. JAL SHALL do the same and also assert reg_write with reg_dst=2, mem_to_reg=2. Both SHALL then go to FETCH.
REQ-022 A wait counter SHALL clear on entry to each memory state and increment each cycle mem_ready=0.
- On reaching MAX_WAIT, the FSM SHALL pulse timeout, drop the memory strobe and return to FETCH.
- mem_ready in the same cycle as the counter reaching MAX_WAIT SHALL count as a successful completion.
REQ-023 When no state asserts a strobe, that strobe SHALL be 0.
- mem_read and mem_write SHALL never be asserted together.
- reg_write and pc_write SHALL never be asserted in memory-wait cycles.

Reset
REQ-024 rst=1 SHALL immediately force state=FETCH, the wait counter to 0, and all strobes and pulses to 0; all selects SHALL go to 0.
REQ-025 Reset asserted mid-access SHALL abandon the access. After release, the first cycle SHALL be a fresh FETCH with mem_read=1.

Structure
REQ-026 Opcode/funct constants, the state encoding and alu_op codes (ADD=0, SUB=1, RTYPE=2) SHALL live in a shared package used by control_unit and ALU_control.
REQ-027 The output decode SHALL be one sub-module, mc_output_decode (state -> strobes); the FSM and wait counter SHALL stay in multicycle_ctrl.

Verification
REQ-028 lw with mem_ready=1 every cycle -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 only in cycle 5.
REQ-029 sw with mem_ready delayed 3 cycles in MEMWR -> mem_write=1 for exactly 4 cycles, then FETCH; no reg_write.
REQ-030 beq with zero=0 -> pc_write_cond=1 in BRANCH; bench checks PC unchanged. With zero=1 -> PC = target.
REQ-031 R-type with funct=001000 (jr) -> pc_write=1, pc_src=3 in EXEC, reg_write=0 throughout; jal -> reg_write=1, reg_dst=2, pc_src=2.
REQ-032 opcode=111111 -> illegal pulse in the DECODE cycle, next state FETCH; mem_ready held 0 for 15 cycles in FETCH -> timeout pulse, refetch.
REQ-033 rst asserted during MEMRD wait -> outputs zero asynchronously, state=FETCH; resumes with mem_read=1 after release.
